// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
package reg_arb_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int ADDR_WIDTH_DEFAULT = 3;
  localparam int NUM_REGS_DEFAULT   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_A_ID = 1'b0,
    REQ_B_ID = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A_ID) ? REQ_B_ID : REQ_A_ID;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; purely combinational, the caller owns the pointer.
module rr_pick2
  import reg_arb_pkg::*;
(
  input  logic    [1:0] eligible,
  input  req_id_t       prio,
  output req_id_t       gnt_id,
  output logic          gnt_valid
);

  // bit 0 is requester A, bit 1 is requester B; prio only matters on a tie
  always_comb begin
    gnt_valid = |eligible;
    gnt_id    = REQ_A_ID;
    if (eligible == 2'b11) begin
      gnt_id = prio;
    end else if (eligible[1]) begin
      gnt_id = REQ_B_ID;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the reg_file write port between two requesters and runs the INIT sweep.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  INIT,
  input  logic [DATA_WIDTH-1:0] INIT_DATA,
  output logic                  BUSY,
  input  logic                  REQ_A,
  input  logic                  REQ_B,
  input  logic [ADDR_WIDTH-1:0] WADDR_A,
  input  logic [ADDR_WIDTH-1:0] WADDR_B,
  input  logic [DATA_WIDTH-1:0] WDATA_A,
  input  logic [DATA_WIDTH-1:0] WDATA_B,
  output logic                  GNT_A,
  output logic                  GNT_B,
  output logic [ADDR_WIDTH-1:0] WRITEREG,
  output logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic                  WRITEENABLE
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  arb_state_t            state;
  req_id_t               prio;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] init_val;
  logic [1:0]            eligible;
  req_id_t               pick_id;
  logic                  pick_valid;

  // a requester still showing its grant this cycle is not eligible again yet
  assign eligible = {REQ_B & ~GNT_B, REQ_A & ~GNT_A};

  rr_pick2 u_pick (
    .eligible  (eligible),
    .prio      (prio),
    .gnt_id    (pick_id),
    .gnt_valid (pick_valid)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      prio        <= REQ_A_ID;
      cnt         <= '0;
      init_val    <= '0;
      BUSY        <= 1'b0;
      GNT_A       <= 1'b0;
      GNT_B       <= 1'b0;
      WRITEENABLE <= 1'b0;
      WRITEREG    <= '0;
      WRITEDATA   <= '0;
    end else begin
      case (state)
        SWEEP: begin
          BUSY        <= 1'b1;
          GNT_A       <= 1'b0;
          GNT_B       <= 1'b0;
          WRITEENABLE <= 1'b1;
          WRITEREG    <= cnt;
          WRITEDATA   <= init_val;
          cnt         <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= IDLE;
          end
        end
        default: begin
          if (INIT) begin
            init_val    <= INIT_DATA;
            cnt         <= '0;
            state       <= SWEEP;
            BUSY        <= 1'b1;
            GNT_A       <= 1'b0;
            GNT_B       <= 1'b0;
            WRITEENABLE <= 1'b0;
          end else begin
            BUSY        <= 1'b0;
            GNT_A       <= pick_valid && (pick_id == REQ_A_ID);
            GNT_B       <= pick_valid && (pick_id == REQ_B_ID);
            WRITEENABLE <= pick_valid;
            // after any grant the other side gets the next tie
            if (pick_valid) begin
              prio      <= other_req(pick_id);
              WRITEREG  <= (pick_id == REQ_A_ID) ? WADDR_A : WADDR_B;
              WRITEDATA <= (pick_id == REQ_A_ID) ? WDATA_A : WDATA_B;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_reg_write_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic [DW-1:0] init_data = '0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [AW-1:0] waddr_a = '0, waddr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          BUSY, GNT_A, GNT_B, WRITEENABLE;
  logic [AW-1:0] WRITEREG;
  logic [DW-1:0] WRITEDATA;

  int assert_count = 0;
  int fail_count = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .CLK(clk), .RESET(rst_n), .INIT(init), .INIT_DATA(init_data), .BUSY(BUSY),
    .REQ_A(req_a), .REQ_B(req_b), .WADDR_A(waddr_a), .WADDR_B(waddr_b),
    .WDATA_A(wdata_a), .WDATA_B(wdata_b), .GNT_A(GNT_A), .GNT_B(GNT_B),
    .WRITEREG(WRITEREG), .WRITEDATA(WRITEDATA), .WRITEENABLE(WRITEENABLE)
  );

  // model: sweep writes are a queue of planned writes; otherwise a simple turn bit settles ties
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sweep_q[$];
  wr_t           cur_wr;
  bit            b_turn = 1'b0;
  bit            elig_a, elig_b;
  logic          exp_busy = 1'b0, exp_gnt_a = 1'b0, exp_gnt_b = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_reg = '0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] exp_mem [NR];
  logic [DW-1:0] shadow_mem [NR];

  initial begin
    for (int i = 0; i < NR; i++) begin
      exp_mem[i] = '0;
      shadow_mem[i] = '0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q.delete();
      b_turn = 1'b0;
      exp_busy = 1'b0; exp_gnt_a = 1'b0; exp_gnt_b = 1'b0; exp_we = 1'b0;
      exp_reg = '0; exp_data = '0;
    end else begin
      if (exp_we) exp_mem[exp_reg] = exp_data;
      elig_a = req_a && !exp_gnt_a;
      elig_b = req_b && !exp_gnt_b;
      exp_gnt_a = 1'b0; exp_gnt_b = 1'b0; exp_we = 1'b0;
      if (sweep_q.size() != 0) begin
        cur_wr = sweep_q.pop_front();
        exp_we = 1'b1; exp_reg = cur_wr.addr; exp_data = cur_wr.data; exp_busy = 1'b1;
      end else if (init) begin
        for (int i = 0; i < NR; i++) sweep_q.push_back('{addr: AW'(i), data: init_data});
        exp_busy = 1'b1;
      end else begin
        exp_busy = 1'b0;
        if (elig_a && (!elig_b || !b_turn)) begin
          exp_gnt_a = 1'b1; exp_we = 1'b1; exp_reg = waddr_a; exp_data = wdata_a; b_turn = 1'b1;
        end else if (elig_b) begin
          exp_gnt_b = 1'b1; exp_we = 1'b1; exp_reg = waddr_b; exp_data = wdata_b; b_turn = 1'b0;
        end
      end
    end
  end

  // what reg_file would hold, built from the DUT's own write port
  always @(posedge clk) begin
    if (WRITEENABLE === 1'b1) shadow_mem[WRITEREG] <= WRITEDATA;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_busy", 32'(BUSY), 32'(exp_busy));
      checkOutput("cyc_gnt_a", 32'(GNT_A), 32'(exp_gnt_a));
      checkOutput("cyc_gnt_b", 32'(GNT_B), 32'(exp_gnt_b));
      checkOutput("cyc_we", 32'(WRITEENABLE), 32'(exp_we));
      checkOutput("cyc_reg", 32'(WRITEREG), 32'(exp_reg));
      checkOutput("cyc_data", 32'(WRITEDATA), 32'(exp_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                               input logic rb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                               input logic in, input logic [DW-1:0] idata);
    req_a = ra; waddr_a = aa; wdata_a = da;
    req_b = rb; waddr_b = ab; wdata_b = db;
    init = in; init_data = idata;
  endtask

  task automatic pulseReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_we", 32'(WRITEENABLE), 32'd0);
    checkOutput("rst_gnt", 32'({GNT_A, GNT_B}), 32'd0);
    checkOutput("rst_reg", 32'(WRITEREG), 32'd0);
    checkOutput("rst_data", 32'(WRITEDATA), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic newReqA();
    req_a = 1'b1; waddr_a = AW'($urandom); wdata_a = DW'($urandom);
  endtask

  task automatic newReqB();
    req_b = 1'b1; waddr_b = AW'($urandom); wdata_b = DW'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_we", 32'(WRITEENABLE), 32'd0);
    checkOutput("reset_gnt", 32'({GNT_A, GNT_B}), 32'd0);
    rst_n = 1'b1;
    check_en = 1'b1;
    tick(); tick();
    checkOutput("idle_we", 32'(WRITEENABLE), 32'd0);

    // single requester, held one cycle longer than needed
    applyStimulus(1'b1, 3'd2, 8'd76, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0);
    tick();
    checkOutput("single_gnt_a", 32'(GNT_A), 32'd1);
    checkOutput("single_we", 32'(WRITEENABLE), 32'd1);
    checkOutput("single_reg", 32'(WRITEREG), 32'd2);
    checkOutput("single_data", 32'(WRITEDATA), 32'd76);
    tick();
    checkOutput("single_no_b2b", 32'(GNT_A), 32'd0);
    checkOutput("single_we_off", 32'(WRITEENABLE), 32'd0);
    checkOutput("single_reg_hold", 32'(WRITEREG), 32'd2);
    tick();
    checkOutput("single_regrant", 32'(GNT_A), 32'd1);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0);
    tick();
    checkOutput("readback_r2", 32'(shadow_mem[2]), 32'd76);
    pulseReset();

    // contention right after reset: A first, then strict alternation
    applyStimulus(1'b1, 3'd1, 8'd28, 1'b1, 3'd4, 8'd6, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("cont_gnt_a", 32'(GNT_A), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("cont_gnt_b", 32'(GNT_B), (i % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("cont_we", 32'(WRITEENABLE), 32'd1);
      checkOutput("cont_reg", 32'(WRITEREG), (i % 2 == 0) ? 32'd1 : 32'd4);
    end
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0);
    tick(); tick();

    // sweep with B pending
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 8'd35, 1'b1, 8'h55);
    tick();
    checkOutput("sw_start_we", 32'(WRITEENABLE), 32'd0);
    checkOutput("sw_start_gnt_b", 32'(GNT_B), 32'd0);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 8'd35, 1'b0, 8'h00);
    for (int i = 0; i < NR; i++) begin
      tick();
      checkOutput("sw_we", 32'(WRITEENABLE), 32'd1);
      checkOutput("sw_reg", 32'(WRITEREG), 32'(i));
      checkOutput("sw_data", 32'(WRITEDATA), 32'h55);
      checkOutput("sw_busy", 32'(BUSY), 32'd1);
      checkOutput("sw_gnt_b", 32'(GNT_B), 32'd0);
    end
    tick();
    checkOutput("sw_after_gnt_b", 32'(GNT_B), 32'd1);
    checkOutput("sw_after_reg", 32'(WRITEREG), 32'd1);
    checkOutput("sw_after_data", 32'(WRITEDATA), 32'd35);
    checkOutput("sw_after_busy", 32'(BUSY), 32'd0);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0);
    tick();
    checkOutput("sw_readback_r1", 32'(shadow_mem[1]), 32'd35);
    checkOutput("sw_readback_r7", 32'(shadow_mem[7]), 32'h55);

    // INIT re-pulsed at cnt=4 must not restart the sweep
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b1, 8'h3c);
    tick();
    for (int i = 0; i < NR; i++) begin
      init = (i == 4);
      tick();
      checkOutput("rep_reg", 32'(WRITEREG), 32'(i));
      checkOutput("rep_data", 32'(WRITEDATA), 32'h3c);
    end
    init = 1'b0;
    tick();
    checkOutput("rep_end_we", 32'(WRITEENABLE), 32'd0);
    checkOutput("rep_end_busy", 32'(BUSY), 32'd0);

    // reset while cnt=3 is on the bus
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b1, 8'haa);
    tick();
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mid_reg", 32'(WRITEREG), 32'(i));
    end
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mid_after_we", 32'(WRITEENABLE), 32'd0);
      checkOutput("mid_after_busy", 32'(BUSY), 32'd0);
    end
    for (int i = 0; i < NR; i++)
      checkOutput("mid_mem", 32'(shadow_mem[i]), (i < 3) ? 32'haa : 32'h3c);

    // random traffic obeying the requester handshake
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 199) == 0) pulseReset();
      init = ($urandom_range(0, 29) == 0);
      init_data = DW'($urandom);
      if (req_a && GNT_A) begin
        if ($urandom_range(0, 1) == 0) req_a = 1'b0; else newReqA();
      end else if (!req_a && $urandom_range(0, 2) == 0) begin
        newReqA();
      end
      if (req_b && GNT_B) begin
        if ($urandom_range(0, 1) == 0) req_b = 1'b0; else newReqB();
      end else if (!req_b && $urandom_range(0, 2) == 0) begin
        newReqB();
      end
      tick();
    end
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0, 8'd0);
    repeat (12) tick();
    for (int i = 0; i < NR; i++)
      checkOutput("final_mem", 32'(shadow_mem[i]), 32'(exp_mem[i]));

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Sequencer and arbiter for the single write port of the 8×8 register file (`reg_file`). It shares that port between two requesters, A (the CPU datapath) and B (the debug/loader path), using registered round-robin grants. On command it runs an 8-cycle initialisation sweep that writes one value into every register. It sits directly in front of `reg_file` and drives its `WRITEREG`, `WRITEDATA` and `WRITEENABLE` inputs.

## Interface
- `DATA_WIDTH`, default 8: register width.
- `ADDR_WIDTH`, default 3: register index width.
- `NUM_REGS`, default 8: registers swept by INIT; must equal 2^ADDR_WIDTH.

Ports:
- `CLK`  in  1  clock; every action happens on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `INIT`  in  1  start an initialisation sweep; sampled each edge.
- `INIT_DATA`  in  DATA_WIDTH  sweep value; latched when INIT is accepted.
- `BUSY`  out  1  high while the sweep runs.
- `REQ_A`, `REQ_B`  in  1  write requests.
- `WADDR_A`, `WADDR_B`  in  ADDR_WIDTH  target register for each requester.
- `WDATA_A`, `WDATA_B`  in  DATA_WIDTH  write data for each requester.
- `GNT_A`, `GNT_B`  out  1  one-cycle pulse: the request was captured.
- `WRITEREG`  out  ADDR_WIDTH  to `reg_file`.
- `WRITEDATA`  out  DATA_WIDTH  to `reg_file`.
- `WRITEENABLE`  out  1  to `reg_file`.

## Operation
- States: IDLE and SWEEP. Round-robin pointer `prio` ∈ {A, B}. Sweep counter `cnt` is ADDR_WIDTH bits.
- Reset (RESET=0) forces, immediately and asynchronously:
  - state=IDLE, prio=A, cnt=0;
  - all outputs 0, namely BUSY, GNT_A, GNT_B, WRITEENABLE, WRITEREG and WRITEDATA.
- IDLE, INIT=1 at an edge:
  - latch INIT_DATA, cnt←0, state←SWEEP;
  - no grant is issued at that edge. INIT has priority over requests.
- SWEEP, each edge:
  - drive WRITEENABLE=1, WRITEREG=cnt, WRITEDATA=latched value, BUSY=1;
  - cnt increments by 1;
  - after driving cnt=NUM_REGS-1, state←IDLE.
  - INIT is ignored throughout. Requests wait and receive no GNT.
- IDLE, no INIT:
  - Eligible requester: REQ_x=1 and GNT_x=0 in the current cycle. This blocks a double capture while the requester is still dropping REQ.
  - Both eligible: grant `prio`, then toggle `prio`.
  - One eligible: grant it, and set `prio` to the other requester.
  - On grant: next cycle drive GNT_x=1, WRITEENABLE=1, WRITEREG=WADDR_x, WRITEDATA=WDATA_x, with addr/data captured at the grant edge.
  - No grant: WRITEENABLE=0 and GNT=0. WRITEREG/WRITEDATA hold their last values.
- Requester rule: hold REQ, WADDR and WDATA stable until GNT_x is seen, then drop REQ or present a new request.
- At most one write per cycle, so no same-register conflict is possible.

## Timing
- All outputs are registered; no combinational input→output path.
- Grant latency: REQ sampled at edge k → GNT/WRITEENABLE high during cycle k→k+1 → `reg_file` writes at edge k+1.
- A continuously held REQ from one requester alone is granted every other cycle.
- Both held continuously: grants alternate A, B, A, B with no idle cycles, and WRITEENABLE stays high.
- Sweep: INIT accepted at edge k → WRITEENABLE high for cycles k+1…k+8, WRITEREG 0…7 → first request grant appears in cycle k+9.
- Reset released mid-sweep: the block restarts in IDLE. The sweep does not resume.

## Structure
- Package `reg_arb_pkg` holds:
  - the state enum (IDLE, SWEEP);
  - the requester enum (REQ_A_ID, REQ_B_ID);
  - the width and count constants.
- Sub-module `rr_pick2`: a two-way round-robin picker, with inputs eligible[1:0] and prio, and outputs grant id and grant-valid. It is purely combinational; the top level owns all the flops.

## Test plan
- Reset: RESET=0 mid-cycle → all outputs 0 without a clock edge. After release, an idle bus keeps WRITEENABLE=0.
- Single request: REQ_A, WADDR_A=2, WDATA_A=76 → next cycle GNT_A=1, WRITEENABLE=1, WRITEREG=2, WRITEDATA=76 for exactly one cycle. Holding REQ_A does not produce a back-to-back grant. A `reg_file` readback of reg 2 returns 76.
- Contention: REQ_A (1, 28) and REQ_B (4, 6) raised together and held → A, B, A, B on consecutive cycles. After reset the first grant goes to A.
- Sweep: INIT=1 with INIT_DATA=0x55 while REQ_B (1, 35) is pending → 8 cycles of writes to regs 0…7 with 0x55 and BUSY=1. GNT_B follows in the 9th cycle, after which reg 1 reads 35.
- INIT during sweep: re-pulse INIT at cnt=4 → still exactly 8 sweep cycles, with no restart.
- Reset mid-sweep: RESET=0 at cnt=3 → BUSY and WRITEENABLE drop to 0 immediately. After release the block is IDLE with no further sweep writes, and regs 3…7 are not rewritten.
